// File: rtl/noise_gen.sv
// Sample-and-hold noise source: a 16-bit maximal-length Fibonacci LFSR that
// advances once every `period` clocks and exposes its top byte as the sample.
module noise_gen #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] period,
  output logic [7:0]  value
);

  // A zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q, lfsr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] eff_m1;
  logic        step;
  logic        fb;

  always_comb begin
    eff_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;
    step   = (cnt_q >= eff_m1);
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  end

  always_comb begin
    cnt_d  = step ? 32'd0 : cnt_q + 32'd1;
    lfsr_d = lfsr_q;
    if (lfsr_q == 16'h0000) begin
      lfsr_d = SEED_EFF;
    end else if (step) begin
      lfsr_d = {fb, lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= SEED_EFF;
      cnt_q  <= 32'd0;
    end else begin
      lfsr_q <= lfsr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign value = lfsr_q[15:8];

endmodule

// File: tb/tb_noise_gen.sv
// Directed checks for noise_gen: reset state, step latency, period 0/1 equivalence,
// full-cycle return to seed, mid-count period change and mid-count reset.
module tb_noise_gen;

  logic        clk;
  logic        reset;
  logic [31:0] period;
  logic [7:0]  value;

  int passed;
  int total;

  noise_gen #(.SEED(16'hACE1)) dut (
    .clk    (clk),
    .reset  (reset),
    .period (period),
    .value  (value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  // Advance one rising edge, then settle 1 time unit past it for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] p);
    period = p;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'd64);
    total++;
    if (value !== 8'hAC) $display("[TB] FAIL reset_value got %h expected %h", value, 8'hAC);
    else passed++;
    total++;
    if (dut.cnt_q !== 32'd0) $display("[TB] FAIL reset_cnt got %0d expected %0d", dut.cnt_q, 0);
    else passed++;
    repeat (16) tick();
    total++;
    if (value !== 8'hAC) $display("[TB] FAIL reset_hold16 got %h expected %h", value, 8'hAC);
    else passed++;
    total++;
    if (dut.cnt_q !== 32'd16) $display("[TB] FAIL reset_cnt16 got %0d expected %0d", dut.cnt_q, 16);
    else passed++;
  endtask

  task automatic test_period64();
    do_reset(32'd64);
    for (int i = 1; i <= 63; i++) begin
      tick();
      total++;
      if (value !== 8'hAC) $display("[TB] FAIL p64_hold edge %0d got %h expected %h", i, value, 8'hAC);
      else passed++;
    end
    tick();
    total++;
    if (value !== 8'h56) $display("[TB] FAIL p64_step1 got %h expected %h", value, 8'h56);
    else passed++;
    for (int i = 65; i <= 127; i++) begin
      tick();
      total++;
      if (value !== 8'h56) $display("[TB] FAIL p64_hold2 edge %0d got %h expected %h", i, value, 8'h56);
      else passed++;
    end
    tick();
    total++;
    if (value !== 8'hAB) $display("[TB] FAIL p64_step2 got %h expected %h", value, 8'hAB);
    else passed++;
  endtask

  task automatic test_fast_periods();
    logic [7:0] seq0 [0:7];
    logic [7:0] exp_v;
    logic [15:0] model;
    for (int pass_i = 0; pass_i < 2; pass_i++) begin
      do_reset((pass_i == 0) ? 32'd0 : 32'd1);
      model = 16'hACE1;
      for (int i = 0; i < 8; i++) begin
        tick();
        model = lfsr_next(model);
        exp_v = model[15:8];
        if (i == 0) exp_v = 8'h56;
        if (i == 1) exp_v = 8'hAB;
        if (i == 2) exp_v = 8'h55;
        total++;
        if (value !== exp_v)
          $display("[TB] FAIL fast_p%0d step %0d got %h expected %h", pass_i, i, value, exp_v);
        else passed++;
        if (pass_i == 0) seq0[i] = value;
        else begin
          total++;
          if (value !== seq0[i])
            $display("[TB] FAIL p0_vs_p1 step %0d got %h expected %h", i, value, seq0[i]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_full_cycle();
    int zero_seen;
    int first_return;
    do_reset(32'd1);
    zero_seen    = 0;
    first_return = -1;
    for (int i = 1; i <= 65535; i++) begin
      tick();
      if (dut.lfsr_q == 16'h0000) zero_seen++;
      if (dut.lfsr_q == 16'hACE1 && first_return < 0) first_return = i;
    end
    total++;
    if (zero_seen !== 0) $display("[TB] FAIL cycle_no_zero got %0d expected %0d", zero_seen, 0);
    else passed++;
    total++;
    if (dut.lfsr_q !== 16'hACE1) $display("[TB] FAIL cycle_end got %h expected %h", dut.lfsr_q, 16'hACE1);
    else passed++;
    total++;
    if (first_return !== 65535) $display("[TB] FAIL cycle_length got %0d expected %0d", first_return, 65535);
    else passed++;
  endtask

  task automatic test_period_change();
    do_reset(32'd100);
    repeat (50) tick();
    total++;
    if (value !== 8'hAC) $display("[TB] FAIL chg_before got %h expected %h", value, 8'hAC);
    else passed++;
    period = 32'd10;
    tick();
    total++;
    if (value !== 8'h56) $display("[TB] FAIL chg_immediate got %h expected %h", value, 8'h56);
    else passed++;
    total++;
    if (dut.cnt_q !== 32'd0) $display("[TB] FAIL chg_cnt_wrap got %0d expected %0d", dut.cnt_q, 0);
    else passed++;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++;
      if (value !== 8'h56) $display("[TB] FAIL chg_hold %0d got %h expected %h", i, value, 8'h56);
      else passed++;
    end
    tick();
    total++;
    if (value !== 8'hAB) $display("[TB] FAIL chg_step10 got %h expected %h", value, 8'hAB);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset(32'd8);
    repeat (8) tick();
    total++;
    if (value !== 8'h56) $display("[TB] FAIL mrst_prestep got %h expected %h", value, 8'h56);
    else passed++;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (value !== 8'hAC) $display("[TB] FAIL mrst_value got %h expected %h", value, 8'hAC);
    else passed++;
    total++;
    if (dut.cnt_q !== 32'd0) $display("[TB] FAIL mrst_cnt got %0d expected %0d", dut.cnt_q, 0);
    else passed++;
    for (int i = 1; i <= 7; i++) begin
      tick();
      total++;
      if (value !== 8'hAC) $display("[TB] FAIL mrst_hold %0d got %h expected %h", i, value, 8'hAC);
      else passed++;
    end
    tick();
    total++;
    if (value !== 8'h56) $display("[TB] FAIL mrst_step got %h expected %h", value, 8'h56);
    else passed++;
  endtask

  task automatic test_max_period();
    do_reset(32'hFFFF_FFFF);
    repeat (20) tick();
    total++;
    if (value !== 8'hAC) $display("[TB] FAIL maxp_hold got %h expected %h", value, 8'hAC);
    else passed++;
    total++;
    if (dut.cnt_q !== 32'd20) $display("[TB] FAIL maxp_cnt got %0d expected %0d", dut.cnt_q, 20);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    reset  = 1'b0;
    period = 32'd64;
    #2;
    test_reset();
    test_period64();
    test_fast_periods();
    test_full_cycle();
    test_period_change();
    test_mid_reset();
    test_max_period();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
